mux_arb_reg: RTL
================

// Module: mux_arb_reg
// PURPOSE
// - Parametrised N-way, WIDTH-bit input selector with a registered output stage and valid/ready handshake.
// - Two modes: directed (external sel picks the source) or round-robin arbitration among valid sources.
// - Serves multi-source datapath points (register-file write-back, memory-address source) where producers may stall.
// PARAMETERS
// - N      8   number of input channels, >= 2
// - WIDTH  16  data width per channel
// - SELW   $clog2(N)  width of sel and out_src (derived, do not override)
// PORTS
// - clk        in   1          rising-edge clock
// - reset      in   1          asynchronous, active-high reset
// - in_data    in   N*WIDTH    channel i at bits [i*WIDTH +: WIDTH]
// - in_valid   in   N          channel i presents data
// - in_ready   out  N          channel i's data is captured this cycle (at most one bit high)
// - mode       in   1          0 = directed, 1 = round-robin
// - sel        in   SELW       source index in directed mode; ignored in round-robin mode
// - out_data   out  WIDTH      registered selected data
// - out_valid  out  1          out_data holds an untaken word
// - out_ready  in   1          consumer accepts out_data this cycle
// - out_src    out  SELW       index of the channel that supplied out_data
// - out_par    out  1          even parity of out_data (MUX_ARB_PARITY_EN only)
// BEHAVIOUR
// - Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, out_par=0, rr_ptr=0.
// - Output stage states: EMPTY (out_valid=0) and FULL (out_valid=1).
// - load_en = !out_valid | out_ready (combinational). Capture happens when load_en and a grant exist.
// - Directed grant: channel sel if sel < N and in_valid[sel]; otherwise no grant.
// - Round-robin grant: first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... wrapping modulo N.
// - in_ready[g] = load_en & grant_valid for granted channel g; all other in_ready bits are 0.
//   in_ready is never high for a channel with in_valid low.
// - On capture: out_data <= channel g data, out_src <= g, out_valid <= 1. Latency is 1 cycle.
// - FULL with out_ready=1 and no grant: out_valid <= 0, out_data/out_src keep their last value.
// - FULL with out_ready=0: all outputs hold, in_ready=0 (backpressure).
// - Simultaneous drain and capture in FULL: the new word replaces the old in the same edge.
//   Sustained throughput is 1 word/cycle.
// - rr_ptr <= (g+1) mod N only on a capture made in round-robin mode. Wrap is g=N-1 -> 0.
//   Directed captures leave rr_ptr unchanged.
// - mode/sel changes take effect on the grant computed in the same cycle. No word in flight is affected.
// - A reset asserted mid-transfer discards the registered word. No in_ready pulse is generated while reset is high.
// CONFIGURATION
// - MUX_ARB_PARITY_EN defined: out_par port exists. It is registered with out_data as ^channel data and reset to 0.
// - MUX_ARB_PARITY_EN undefined: out_par port and its logic are absent. All other behaviour is identical.
// STRUCTURE
// - Package mux_arb_pkg holds the MODE_DIRECTED=1'b0 / MODE_RR=1'b1 constants and the clog2 helper used for SELW.
// - Sub-module rr_arbiter (N): inputs req[N] and ptr[SELW]; outputs gnt_valid and gnt_idx. It is purely combinational.
//   The pointer register, muxing and output stage stay in mux_arb_reg.
// TESTING (N=8, WIDTH=16 unless stated)
// - Reset: assert reset mid-stream -> out_valid=0, out_data=0, out_src=0, in_ready=0 in the same cycle, before any clk edge.
// - Directed: mode=0, sel=5, in_valid=8'h20, data5=16'hBEEF, out_ready=1 -> next cycle out_data=BEEF, out_src=5.
//   in_ready was 8'h20 in the capture cycle.
// - Directed, invalid source: sel=3, in_valid=8'h20 -> in_ready=0, out_valid stays 0.
// - Round-robin fairness: mode=1, in_valid=8'hFF held, out_ready=1 -> out_src sequence 0,1,...,7,0 across 9 cycles.
// - Round-robin skip: in_valid=8'h81, rr_ptr=1 -> grant 7, then grant 0, then grant 7.
// - Backpressure: FULL, out_ready=0 for 3 cycles -> out_data stable, in_ready=0.
//   Then out_ready=1 with a new valid word -> replaced in 1 cycle with no bubble.
// - N=5 directed with sel=6 -> no grant.
// - With MUX_ARB_PARITY_EN: data 16'h0007 -> out_par=1.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants, output-stage state type and width helper for the mux_arb_reg slice.
package mux_arb_pkg;

    localparam logic MODE_DIRECTED = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Index width for n items (at least 1 bit).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping modulo N.
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    int unsigned     idx;
    logic [SELW-1:0] idx_s;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        idx_s     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx   = (32'(ptr) + k) % N;
            idx_s = SELW'(idx);
            if (!gnt_valid && req[idx_s]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx_s;
            end
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// N-way selector with registered output and valid/ready handshake; directed or round-robin source choice.
// Optional out_par port enabled by defining MUX_ARB_PARITY_EN.
module mux_arb_reg
    import mux_arb_pkg::*;
#(
    parameter int N     = 8,
    parameter int WIDTH = 16,
    parameter int SELW  = clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_src
`ifdef MUX_ARB_PARITY_EN
    ,
    output logic               out_par
`endif
);

    out_state_t      state, state_nxt;
    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] rr_next;

    logic            rr_valid;
    logic [SELW-1:0] rr_idx;
    logic            dir_valid;
    logic            grant_valid;
    logic [SELW-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic            load_en;
    logic            capture;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Directed grant walks the channels so an out-of-range sel simply matches none.
    always_comb begin
        dir_valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(sel) == i && in_valid[i]) begin
                dir_valid = 1'b1;
            end
        end
    end

    always_comb begin
        grant_valid = (mode == MODE_RR) ? rr_valid : dir_valid;
        grant_idx   = (mode == MODE_RR) ? rr_idx : sel;
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(grant_idx) == i) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign out_valid = (state == ST_FULL);
    assign load_en   = !out_valid || out_ready;
    // Gating with reset keeps in_ready silent while the output stage is held clear.
    assign capture   = load_en && grant_valid && !reset;
    assign rr_next   = (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = capture && (32'(grant_idx) == i);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (capture) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (capture) begin
                    state_nxt = ST_FULL;
                end else if (out_ready) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_src  <= '0;
            rr_ptr   <= '0;
        end else begin
            if (capture) begin
                out_data <= grant_data;
                out_src  <= grant_idx;
            end
            if (capture && mode == MODE_RR) begin
                rr_ptr <= rr_next;
            end
        end
    end

`ifdef MUX_ARB_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_par <= 1'b0;
        end else if (capture) begin
            out_par <= ^grant_data;
        end
    end
`endif

endmodule
